// File: rtl/net_recv_event_gen.sv
// Packet length meter: counts bytes of each AXI-Stream packet and emits one
// {len, short} event per packet through a small FIFO, counting overflow drops.
module net_recv_event_gen #(
    parameter int unsigned  DATA_WIDTH   = 64,
    localparam int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned  LEN_WIDTH    = 16,
    parameter int unsigned  FIFO_DEPTH   = 4,
    parameter int unsigned  SHORT_THRESH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_pkt_tdata,
    input  logic [KEEP_WIDTH-1:0] s_pkt_tkeep,
    input  logic                  s_pkt_tlast,
    input  logic                  s_pkt_tvalid,
    output logic                  s_pkt_tready,
    output logic [LEN_WIDTH:0]    m_event_tdata,
    output logic                  m_event_tvalid,
    input  logic                  m_event_tready,
    output logic [31:0]           drop_count
);

    localparam int unsigned EVT_W = LEN_WIDTH + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [LEN_WIDTH-1:0] acc_q, acc_d;
    logic [EVT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [EVT_W-1:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [31:0]          drop_q, drop_d;

    logic [EVT_W-1:0]     keep_cnt;
    logic [EVT_W-1:0]     sum;
    logic [LEN_WIDTH-1:0] len;
    logic                 is_short;
    logic                 beat_acc, evt_form, push, pop, full, drop;

    // Packet payload is never inspected; only tkeep contributes.
    logic unused_tdata;
    assign unused_tdata = ^s_pkt_tdata;

    assign s_pkt_tready = ~rst;
    assign beat_acc     = s_pkt_tvalid & s_pkt_tready;
    assign evt_form     = beat_acc & s_pkt_tlast;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + EVT_W'(s_pkt_tkeep[i]);
        end
    end

    // One extra bit of headroom so the sum saturates instead of wrapping.
    assign sum      = {1'b0, acc_q} + keep_cnt;
    assign len      = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    assign is_short = 32'(len) < SHORT_THRESH;

    assign m_event_tvalid = ~rst & (count_q != '0);
    assign m_event_tdata  = m_event_tvalid ? mem_q[rd_q] : '0;
    assign drop_count     = drop_q;

    assign pop  = m_event_tvalid & m_event_tready;
    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign push = evt_form & (~full | pop);
    assign drop = evt_form & ~push;

    always_comb begin
        acc_d   = acc_q;
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        drop_d  = drop_q;

        if (beat_acc) begin
            acc_d = s_pkt_tlast ? '0 : len;
        end
        if (push) begin
            mem_d[wr_q] = {len, is_short};
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            drop_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_net_recv_event_gen.sv
// Directed bench for net_recv_event_gen: default instance plus an 8-bit length
// instance used for the saturation scenario.
module tb_net_recv_event_gen;

    logic        clk;
    logic        rst;
    logic [63:0] s_pkt_tdata;
    logic [7:0]  s_pkt_tkeep;
    logic        s_pkt_tlast;
    logic        s_pkt_tvalid;
    logic        s_pkt_tready;
    logic [16:0] m_event_tdata;
    logic        m_event_tvalid;
    logic        m_event_tready;
    logic [31:0] drop_count;

    logic        s2_tvalid;
    logic        s2_tready;
    logic [8:0]  m2_tdata;
    logic        m2_tvalid;
    logic        m2_tready;
    logic [31:0] drop2_count;

    int tests_run;
    int tests_failed;

    net_recv_event_gen u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_pkt_tdata   (s_pkt_tdata),
        .s_pkt_tkeep   (s_pkt_tkeep),
        .s_pkt_tlast   (s_pkt_tlast),
        .s_pkt_tvalid  (s_pkt_tvalid),
        .s_pkt_tready  (s_pkt_tready),
        .m_event_tdata (m_event_tdata),
        .m_event_tvalid(m_event_tvalid),
        .m_event_tready(m_event_tready),
        .drop_count    (drop_count)
    );

    net_recv_event_gen #(.LEN_WIDTH(8)) u_sat (
        .clk           (clk),
        .rst           (rst),
        .s_pkt_tdata   (s_pkt_tdata),
        .s_pkt_tkeep   (s_pkt_tkeep),
        .s_pkt_tlast   (s_pkt_tlast),
        .s_pkt_tvalid  (s2_tvalid),
        .s_pkt_tready  (s2_tready),
        .m_event_tdata (m2_tdata),
        .m_event_tvalid(m2_tvalid),
        .m_event_tready(m2_tready),
        .drop_count    (drop2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One beat on the selected instance; returns 1 time unit after the edge.
    task automatic send_beat(input logic [7:0] keep, input logic last, input logic sat);
        if (sat) s2_tvalid = 1'b1;
        else     s_pkt_tvalid = 1'b1;
        s_pkt_tkeep = keep;
        s_pkt_tlast = last;
        s_pkt_tdata = {$urandom, $urandom};
        @(posedge clk);
        #1;
        s_pkt_tvalid = 1'b0;
        s2_tvalid    = 1'b0;
        s_pkt_tlast  = 1'b0;
        s_pkt_tkeep  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (s_pkt_tready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_tready got %b want 0", s_pkt_tready);
        end
        tests_run++;
        if (m_event_tvalid !== 1'b0 || m_event_tdata !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_out got v=%b d=%h want v=0 d=0", m_event_tvalid, m_event_tdata);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (s_pkt_tready !== 1'b1 || drop_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL post_reset got rdy=%b drop=%0d want 1/0", s_pkt_tready, drop_count);
        end
    endtask

    task automatic test_single();
        m_event_tready = 1'b0;
        send_beat(8'h0F, 1'b1, 1'b0);
        tests_run++;
        if (m_event_tvalid !== 1'b1 || m_event_tdata !== 17'h0009) begin
            tests_failed++;
            $display("FAIL single got v=%b d=%h want 1/0009", m_event_tvalid, m_event_tdata);
        end
        m_event_tready = 1'b1;
        tick();
        m_event_tready = 1'b0;
        tests_run++;
        if (m_event_tvalid !== 1'b0) begin
            tests_failed++; $display("FAIL single_drain got v=%b want 0", m_event_tvalid);
        end
    endtask

    task automatic test_multi();
        m_event_tready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'hFF, 1'b0, 1'b0);
        tests_run++;
        if (m_event_tvalid !== 1'b0) begin
            tests_failed++; $display("FAIL multi_early got v=%b want 0", m_event_tvalid);
        end
        send_beat(8'hFF, 1'b1, 1'b0);
        tests_run++;
        if (m_event_tvalid !== 1'b1 || m_event_tdata !== 17'h0090) begin
            tests_failed++;
            $display("FAIL multi got v=%b d=%h want 1/0090", m_event_tvalid, m_event_tdata);
        end
        m_event_tready = 1'b1;
        tick();
        m_event_tready = 1'b0;
        send_beat(8'hA5, 1'b0, 1'b0);
        send_beat(8'h01, 1'b1, 1'b0);
        tests_run++;
        if (m_event_tvalid !== 1'b1 || m_event_tdata !== 17'h000B) begin
            tests_failed++;
            $display("FAIL sparse got v=%b d=%h want 1/000B", m_event_tvalid, m_event_tdata);
        end
        m_event_tready = 1'b1;
        tick();
        m_event_tready = 1'b0;
    endtask

    // Lengths 63 and 64 straddle the short threshold.
    task automatic test_threshold();
        m_event_tready = 1'b0;
        for (int i = 0; i < 7; i++) send_beat(8'hFF, 1'b0, 1'b0);
        send_beat(8'h7F, 1'b1, 1'b0);
        tests_run++;
        if (m_event_tdata !== 17'h007F) begin
            tests_failed++; $display("FAIL thresh_63 got %h want 007F", m_event_tdata);
        end
        m_event_tready = 1'b1;
        tick();
        m_event_tready = 1'b0;
        for (int i = 0; i < 7; i++) send_beat(8'hFF, 1'b0, 1'b0);
        send_beat(8'hFF, 1'b1, 1'b0);
        tests_run++;
        if (m_event_tdata !== 17'h0080) begin
            tests_failed++; $display("FAIL thresh_64 got %h want 0080", m_event_tdata);
        end
        m_event_tready = 1'b1;
        tick();
        m_event_tready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] keeps [6];
        keeps = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
        m_event_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_beat(keeps[i], 1'b1, 1'b0);
            tests_run++;
            if (m_event_tvalid !== 1'b1 || m_event_tdata !== 17'h0003) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h want 1/0003", i, m_event_tvalid,
                         m_event_tdata);
            end
        end
        tests_run++;
        if (drop_count !== 32'd2) begin
            tests_failed++; $display("FAIL bp_drop got %0d want 2", drop_count);
        end
        m_event_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (m_event_tvalid !== 1'b1 || m_event_tdata !== 17'(((i + 1) << 1) | 1)) begin
                tests_failed++;
                $display("FAIL bp_drain[%0d] got v=%b d=%h want 1/%h", i, m_event_tvalid,
                         m_event_tdata, 17'(((i + 1) << 1) | 1));
            end
            tick();
        end
        m_event_tready = 1'b0;
        tests_run++;
        if (m_event_tvalid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_empty got v=%b want 0", m_event_tvalid);
        end
    endtask

    task automatic test_full_pop();
        logic [16:0] exp [4];
        exp = '{17'h0003, 17'h0003, 17'h0003, 17'h0011};
        m_event_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b1, 1'b0);
        m_event_tready = 1'b1;
        send_beat(8'hFF, 1'b1, 1'b0);
        m_event_tready = 1'b0;
        tests_run++;
        if (drop_count !== 32'd2) begin
            tests_failed++; $display("FAIL fullpop_drop got %0d want 2", drop_count);
        end
        m_event_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (m_event_tvalid !== 1'b1 || m_event_tdata !== exp[i]) begin
                tests_failed++;
                $display("FAIL fullpop_drain[%0d] got v=%b d=%h want 1/%h", i, m_event_tvalid,
                         m_event_tdata, exp[i]);
            end
            tick();
        end
        m_event_tready = 1'b0;
        tests_run++;
        if (m_event_tvalid !== 1'b0) begin
            tests_failed++; $display("FAIL fullpop_empty got v=%b want 0", m_event_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] keeps [5];
        keeps = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
        m_event_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_beat(keeps[i], 1'b1, 1'b0);
            tests_run++;
            if (m_event_tvalid !== 1'b1 || m_event_tdata !== 17'(((i + 1) << 1) | 1)) begin
                tests_failed++;
                $display("FAIL b2b[%0d] got v=%b d=%h want 1/%h", i, m_event_tvalid,
                         m_event_tdata, 17'(((i + 1) << 1) | 1));
            end
        end
        tick();
        m_event_tready = 1'b0;
        tests_run++;
        if (m_event_tvalid !== 1'b0 || drop_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL b2b_end got v=%b drop=%0d want 0/2", m_event_tvalid, drop_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 39; i++) send_beat(8'hFF, 1'b0, 1'b1);
        send_beat(8'hFF, 1'b1, 1'b1);
        tests_run++;
        if (m2_tvalid !== 1'b1 || m2_tdata !== 9'h1FE) begin
            tests_failed++;
            $display("FAIL saturate got v=%b d=%h want 1/1FE", m2_tvalid, m2_tdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m_event_tready = 1'b0;
        send_beat(8'hFF, 1'b0, 1'b0);
        send_beat(8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        tests_run++;
        if (s_pkt_tready !== 1'b0 || m_event_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_in got rdy=%b v=%b want 0/0", s_pkt_tready, m_event_tvalid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (m_event_tvalid !== 1'b0 || drop_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL rstmid_after got v=%b drop=%0d want 0/0", m_event_tvalid, drop_count);
        end
        send_beat(8'h01, 1'b1, 1'b0);
        tests_run++;
        if (m_event_tvalid !== 1'b1 || m_event_tdata !== 17'h0003) begin
            tests_failed++;
            $display("FAIL rstmid_evt got v=%b d=%h want 1/0003", m_event_tvalid, m_event_tdata);
        end
        m_event_tready = 1'b1;
        tick();
        m_event_tready = 1'b0;
        tests_run++;
        if (m_event_tvalid !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_single got v=%b want 0", m_event_tvalid);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        s_pkt_tdata    = '0;
        s_pkt_tkeep    = '0;
        s_pkt_tlast    = 1'b0;
        s_pkt_tvalid   = 1'b0;
        s2_tvalid      = 1'b0;
        m2_tready      = 1'b1;
        m_event_tready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_multi();
        test_threshold();
        test_backpressure();
        test_full_pop();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/net_recv_event_gen.md
# net_recv_event_gen

Upstream feeder for the generated `NET_RECV` handler pipelines. It consumes a raw AXI-Stream packet interface from the MAC/parser side and measures each packet's byte length. For every packet it emits one `NET_RECV` event struct on an AXI-Stream-style valid/ready event port, buffered in a small FIFO. Packet data itself is discarded; only metadata reaches the handler.

## Interface
Parameters:
- `DATA_WIDTH`, 64: packet data bus width in bits; must be a multiple of 8.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: byte-enable width (derived, not overridden).
- `LEN_WIDTH`, 16: width of the byte-length field in the event.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `SHORT_THRESH`, 64: packets with byte length strictly below this value set the short flag.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `s_pkt_tdata`, input, `DATA_WIDTH`: packet data (ignored).
- `s_pkt_tkeep`, input, `KEEP_WIDTH`: byte enables.
- `s_pkt_tlast`, input, 1: last beat of packet.
- `s_pkt_tvalid`, input, 1: beat valid.
- `s_pkt_tready`, output, 1: beat accepted.
- `m_event_tdata`, output, `LEN_WIDTH+1`: event struct.
  - bit 0 is the short flag.
  - bits `[LEN_WIDTH:1]` are the byte length.
- `m_event_tvalid`, output, 1: event valid.
- `m_event_tready`, input, 1: downstream handler accepts the event.
- `drop_count`, output, 32: number of events dropped because the FIFO was full; saturating.

## Operation
- The packet side is never backpressured. `s_pkt_tready` is 0 while `rst` is high and 1 otherwise. A beat is accepted when `s_pkt_tvalid && s_pkt_tready`.
- Byte accumulator `acc` (width `LEN_WIDTH`):
  - On an accepted non-last beat: `acc <= sat(acc + popcount(s_pkt_tkeep))`.
  - On an accepted last beat: `len = sat(acc + popcount(s_pkt_tkeep))`, then `acc <= 0`.
  - `sat()` clamps to `2^LEN_WIDTH-1`. Intermediate sums are computed one bit wider so no wrap-around occurs.
  - `tkeep` bits need not be contiguous; zero-keep beats contribute 0.
- Event formation on an accepted last beat:
  - Event = `{len, (len < SHORT_THRESH)}`.
  - Comparison is unsigned against the saturated length.
  - A single-beat packet (`tlast` on the first beat) is legal.
- Event FIFO:
  - Circular buffer of `FIFO_DEPTH` entries, with read pointer, write pointer and an occupancy count of `log2(FIFO_DEPTH)+1` bits.
  - Push when an event forms and either (count < `FIFO_DEPTH`) or (a pop occurs in the same cycle).
  - Pop when `m_event_tvalid && m_event_tready`.
  - Simultaneous push and pop: count is unchanged and both pointers advance, including when the FIFO is full.
  - Empty FIFO with a push: the event is not bypassed combinationally; it appears on the next cycle.
- Drop:
  - An event that forms while the FIFO is full and no pop occurs is discarded, and `drop_count` increments by 1.
  - `drop_count` saturates at `0xFFFF_FFFF`.
- Output:
  - `m_event_tvalid = (count != 0)`.
  - `m_event_tdata` is the entry at the read pointer. It is held stable while valid and not ready.
  - Event order matches packet order.
- Reset:
  - On reset, `acc`, pointers, count and `drop_count` all become 0.
  - Outputs during and after reset: `m_event_tvalid=0`, `m_event_tdata=0`, `s_pkt_tready=0` while in reset.
  - A packet partially received when reset asserts is discarded. The next accepted beat after reset starts a new packet.

## Timing
- Latency: `tlast` beat accepted in cycle T → event visible with `m_event_tvalid=1` in cycle T+1, provided the FIFO is not full.
- Throughput:
  - One event per cycle in and one event per cycle out.
  - Back-to-back single-beat packets are sustained indefinitely while `m_event_tready=1`.
- The first accepted beat is the cycle after `rst` deasserts.
- `drop_count` updates in the cycle after the dropped `tlast` beat.
- No combinational path from `m_event_tready` to `m_event_tvalid` or `m_event_tdata`, nor from the `s_pkt_*` inputs to the `m_event_*` outputs.

## Test plan
All scenarios use defaults (`DATA_WIDTH`=64, `LEN_WIDTH`=16, `FIFO_DEPTH`=4, `SHORT_THRESH`=64) unless noted.
- Single beat: `tkeep`=0x0F, `tlast`=1 → next cycle `m_event_tvalid`=1, `m_event_tdata`=0x0009 (len 4, short 1).
- Multi-beat: 9 beats with `tkeep`=0xFF, the last with `tlast` → `m_event_tdata`=0x0090 (len 72, short 0). Sparse variant: `tkeep` 0xA5, 0x01 (last) → len 5, `tdata`=0x000B.
- Backpressure and drop:
  - Stimulus: `m_event_tready`=0; six one-beat packets with `tkeep` 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F.
  - Required: `m_event_tvalid` stays 1 with `tdata`=0x0003 held stable; `drop_count`=2.
  - Then raise `m_event_tready`: lengths 1, 2, 3, 4 drain in order, then `m_event_tvalid`=0.
- Full plus simultaneous pop: with the FIFO full and `m_event_tready`=1, a packet ends with `tkeep`=0xFF in the same cycle → event accepted, `drop_count` unchanged, count stays 4.
- Saturation: instance with `LEN_WIDTH`=8; 40 full beats (320 bytes) → len 255, short 0, `tdata`=0x1FE.
- Reset mid-packet:
  - Stimulus: 2 full non-last beats, `rst` pulsed for 1 cycle, then a one-beat packet with `tkeep`=0x01.
  - Required: `s_pkt_tready`=0 during reset; `m_event_tvalid`=0 during and after reset until the new event; the single event has len 1 (`tdata`=0x0003) with no residue from the first 16 bytes.
